zap_branch_state_ctrl: RTL and testbench

ZAP_BRANCH_STATE_CTRL -- requirements
Module: zap_branch_state_ctrl

---
 rtl/zap_branch_state_ctrl.sv | 125 ++++++++++++
 tb/tb_zap_branch_state_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_branch_state_ctrl.sv
// zap_branch_state_ctrl
//   Branch-state table. Each entry holds a 2-bit saturating counter
//   (SNT=0, WNT=1, WT=2, ST=3). After reset the table is swept to WNT,
//   one entry per cycle. A fetch lookup returns its state one cycle later.
//   A resolved branch writes back a new state, which is derived from the
//   state the branch carried down the pipe.
//
// Ports
//   i_clk            core clock
//   i_reset          synchronous active-high reset
//   i_code_stall     hold lookup outputs
//   i_clear          discard pending lookup
//   i_rd_valid       fetch lookup request
//   i_rd_pc          fetch PC
//   i_upd_valid      resolved-branch update
//   i_upd_pc         PC of resolved branch
//   i_upd_state      state carried with the branch
//   i_upd_taken      actual outcome (1 = taken)
//   o_taken_ff       predicted state for the lookup
//   o_taken_valid_ff o_taken_ff qualifies a lookup
//   o_init_busy      table sweep in progress; fetch must stall
module zap_branch_state_ctrl #(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_code_stall,
  input  logic        i_clear,
  input  logic        i_rd_valid,
  input  logic [31:0] i_rd_pc,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [1:0]  i_upd_state,
  input  logic        i_upd_taken,
  output logic [1:0]  o_taken_ff,
  output logic        o_taken_valid_ff,
  output logic        o_init_busy
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam logic [IDX-1:0] LastIdx = IDX'(ENTRIES - 1);

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic {StInit, StRun} state_t;

  state_t           r_state;
  logic [IDX-1:0]   r_ptr;
  logic [1:0]       r_taken;
  logic             r_taken_valid;
  logic [1:0]       r_mem [ENTRIES];

  logic [IDX-1:0]   w_rd_idx;
  logic [IDX-1:0]   w_upd_idx;
  logic [1:0]       w_upd_new;
  logic             w_upd_en;
  logic [1:0]       w_lookup;
  logic             w_unused;

  // Bit 0 is skipped so Thumb (halfword) and ARM PCs share the same index.
  assign w_rd_idx  = i_rd_pc[IDX:1];
  assign w_upd_idx = i_upd_pc[IDX:1];
  assign w_unused  = ^{i_rd_pc[31:IDX+1], i_rd_pc[0], i_upd_pc[31:IDX+1], i_upd_pc[0]};

  // New state comes only from the carried state, never from table contents.
  always_comb begin
    w_upd_new = i_upd_state;
    if (i_upd_taken) begin
      if (i_upd_state != ST) w_upd_new = i_upd_state + 2'd1;
    end else begin
      if (i_upd_state != SNT) w_upd_new = i_upd_state - 2'd1;
    end
  end

  // Updates are dropped while the sweep owns the write port.
  assign w_upd_en = (r_state == StRun) && i_upd_valid;

  // Same-index update bypasses so the lookup sees the value being written.
  always_comb begin
    w_lookup = r_mem[w_rd_idx];
    if (r_state == StInit) begin
      w_lookup = WNT;
    end else if (w_upd_en && (w_upd_idx == w_rd_idx)) begin
      w_lookup = w_upd_new;
    end
  end

  // Table storage: no reset, the sweep initialises it.
  always_ff @(posedge i_clk) begin
    if (r_state == StInit) begin
      r_mem[r_ptr] <= WNT;
    end else if (w_upd_en) begin
      r_mem[w_upd_idx] <= w_upd_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StInit;
      r_ptr         <= '0;
      r_taken       <= SNT;
      r_taken_valid <= 1'b0;
    end else begin
      if (r_state == StInit) begin
        r_ptr <= r_ptr + IDX'(1);
        if (r_ptr == LastIdx) r_state <= StRun;
      end

      if (i_clear) begin
        r_taken       <= SNT;
        r_taken_valid <= 1'b0;
      end else if (!i_code_stall) begin
        r_taken_valid <= i_rd_valid;
        r_taken       <= i_rd_valid ? w_lookup : SNT;
      end
    end
  end

  assign o_taken_ff       = r_taken;
  assign o_taken_valid_ff = r_taken_valid;
  assign o_init_busy      = (r_state == StInit);

endmodule

// File: tb/tb_zap_branch_state_ctrl.sv
module tb_zap_branch_state_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_code_stall = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_rd_valid = 1'b0;
  logic [31:0] i_rd_pc = '0;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic [1:0]  i_upd_state = '0;
  logic        i_upd_taken = 1'b0;
  logic [1:0]  o_taken_ff;
  logic        o_taken_valid_ff;
  logic        o_init_busy;

  int n_checks = 0;
  int n_fail   = 0;

  zap_branch_state_ctrl #(.ENTRIES(64)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_code_stall    (i_code_stall),
    .i_clear         (i_clear),
    .i_rd_valid      (i_rd_valid),
    .i_rd_pc         (i_rd_pc),
    .i_upd_valid     (i_upd_valid),
    .i_upd_pc        (i_upd_pc),
    .i_upd_state     (i_upd_state),
    .i_upd_taken     (i_upd_taken),
    .o_taken_ff      (o_taken_ff),
    .o_taken_valid_ff(o_taken_valid_ff),
    .o_init_busy     (o_init_busy)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_code_stall = 1'b0;
    i_clear      = 1'b0;
    i_rd_valid   = 1'b0;
    i_upd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    i_reset = 1'b1;
    idle_inputs();
    tick();
    n_checks++;
    if (o_init_busy !== 1'b1 || o_taken_valid_ff !== 1'b0 || o_taken_ff !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b valid=%b taken=%0d required busy=1 valid=0 taken=0",
               o_init_busy, o_taken_valid_ff, o_taken_ff);
    end
    i_reset = 1'b0;
    cnt = 0;
    while (o_init_busy === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 64) begin
      n_fail++;
      $display("FAIL init_busy_len got %0d cycles required 64", cnt);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pcs [4];
      pcs = '{32'h0, 32'h2, 32'h7e, 32'h1234};
      i_rd_valid = 1'b1;
      i_rd_pc    = pcs[i];
      tick();
      n_checks++;
      if (o_taken_ff !== 2'd1 || o_taken_valid_ff !== 1'b1) begin
        n_fail++;
        $display("FAIL init_value pc=%h got taken=%0d valid=%b required taken=1 valid=1",
                 pcs[i], o_taken_ff, o_taken_valid_ff);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_update_lookup();
    logic [1:0] st [2];
    logic [1:0] ex [2];
    st = '{2'd1, 2'd3};
    ex = '{2'd2, 2'd3};
    for (int i = 0; i < 2; i++) begin
      i_upd_valid = 1'b1;
      i_upd_pc    = 32'h100;
      i_upd_state = st[i];
      i_upd_taken = 1'b1;
      tick();
      i_upd_valid = 1'b0;
      i_rd_valid  = 1'b1;
      i_rd_pc     = 32'h100;
      tick();
      n_checks++;
      if (o_taken_ff !== ex[i] || o_taken_valid_ff !== 1'b1) begin
        n_fail++;
        $display("FAIL update_lookup state=%0d got taken=%0d valid=%b required taken=%0d valid=1",
                 st[i], o_taken_ff, o_taken_valid_ff, ex[i]);
      end
      i_rd_valid = 1'b0;
    end
  endtask

  task automatic test_bypass();
    // Same index: lookup must see the value being written.
    i_upd_valid = 1'b1;
    i_upd_pc    = 32'h40;
    i_upd_state = 2'd2;
    i_upd_taken = 1'b1;
    i_rd_valid  = 1'b1;
    i_rd_pc     = 32'h40;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd3 || o_taken_valid_ff !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_same got taken=%0d valid=%b required taken=3 valid=1",
               o_taken_ff, o_taken_valid_ff);
    end
    // Different indices in the same cycle.
    i_upd_pc = 32'h10;
    i_rd_pc  = 32'h20;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd1 || o_taken_valid_ff !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_diff_rd got taken=%0d valid=%b required taken=1 valid=1",
               o_taken_ff, o_taken_valid_ff);
    end
    i_upd_valid = 1'b0;
    i_rd_pc     = 32'h10;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd3) begin
      n_fail++;
      $display("FAIL bypass_diff_upd got taken=%0d required 3", o_taken_ff);
    end
    i_rd_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] pc [3];
    logic [1:0]  st [3];
    logic        tk [3];
    logic [1:0]  ex [3];
    // Third vector: table holds 2 at pc 0x6, carried state 0 must win.
    pc = '{32'h4, 32'h6, 32'h6};
    st = '{2'd0, 2'd3, 2'd0};
    tk = '{1'b0, 1'b0, 1'b1};
    ex = '{2'd0, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) begin
      i_upd_valid = 1'b1;
      i_upd_pc    = pc[i];
      i_upd_state = st[i];
      i_upd_taken = tk[i];
      tick();
      i_upd_valid = 1'b0;
      i_rd_valid  = 1'b1;
      i_rd_pc     = pc[i];
      tick();
      i_rd_valid = 1'b0;
      n_checks++;
      if (o_taken_ff !== ex[i]) begin
        n_fail++;
        $display("FAIL saturation vec=%0d got taken=%0d required %0d", i, o_taken_ff, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc [5];
    logic [1:0]  ex [5];
    pc = '{32'h100, 32'h40, 32'h4, 32'h6, 32'h20};
    ex = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd1};
    i_rd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_rd_pc = pc[i];
      tick();
      n_checks++;
      if (o_taken_ff !== ex[i] || o_taken_valid_ff !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back pc=%h got taken=%0d valid=%b required taken=%0d valid=1",
                 pc[i], o_taken_ff, o_taken_valid_ff, ex[i]);
      end
    end
    i_rd_valid = 1'b0;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd0 || o_taken_valid_ff !== 1'b0) begin
      n_fail++;
      $display("FAIL no_request got taken=%0d valid=%b required taken=0 valid=0",
               o_taken_ff, o_taken_valid_ff);
    end
  endtask

  task automatic test_stall_clear();
    i_rd_valid = 1'b1;
    i_rd_pc    = 32'h8;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd1 || o_taken_valid_ff !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_pre got taken=%0d valid=%b required taken=1 valid=1",
               o_taken_ff, o_taken_valid_ff);
    end
    // Point the lookup at an entry holding 3 so a missed hold is visible.
    i_code_stall = 1'b1;
    i_rd_pc      = 32'h40;
    i_upd_valid  = 1'b1;
    i_upd_pc     = 32'h8;
    i_upd_state  = 2'd2;
    i_upd_taken  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      i_upd_valid = 1'b0;
      n_checks++;
      if (o_taken_ff !== 2'd1 || o_taken_valid_ff !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got taken=%0d valid=%b required taken=1 valid=1",
                 i, o_taken_ff, o_taken_valid_ff);
      end
    end
    i_clear = 1'b1;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd0 || o_taken_valid_ff !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_clear got taken=%0d valid=%b required taken=0 valid=0",
               o_taken_ff, o_taken_valid_ff);
    end
    i_clear      = 1'b0;
    i_code_stall = 1'b0;
    i_rd_pc      = 32'h8;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd3 || o_taken_valid_ff !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_update got taken=%0d valid=%b required taken=3 valid=1",
               o_taken_ff, o_taken_valid_ff);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_init();
    int cnt;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    // Update and lookup issued in INIT: update dropped, lookup returns WNT.
    i_upd_valid = 1'b1;
    i_upd_pc    = 32'h40;
    i_upd_state = 2'd2;
    i_upd_taken = 1'b1;
    i_rd_valid  = 1'b1;
    i_rd_pc     = 32'h40;
    tick();
    cnt = 1;
    idle_inputs();
    n_checks++;
    if (o_taken_ff !== 2'd1 || o_taken_valid_ff !== 1'b1 || o_init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL init_lookup got taken=%0d valid=%b busy=%b required taken=1 valid=1 busy=1",
               o_taken_ff, o_taken_valid_ff, o_init_busy);
    end
    while (o_init_busy === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 64) begin
      n_fail++;
      $display("FAIL reinit_busy_len got %0d cycles required 64", cnt);
    end
    i_rd_valid = 1'b1;
    i_rd_pc    = 32'h40;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd1) begin
      n_fail++;
      $display("FAIL init_drop_update got taken=%0d required 1", o_taken_ff);
    end
    i_rd_pc = 32'h100;
    tick();
    n_checks++;
    if (o_taken_ff !== 2'd1) begin
      n_fail++;
      $display("FAIL reinit_entry0 got taken=%0d required 1", o_taken_ff);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_update_lookup();
    test_bypass();
    test_saturation();
    test_back_to_back();
    test_stall_clear();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
